// File: rtl/frame_sender_pkg.sv
// Shared FSM state encoding and default parameter values for the serial frame sender.
package sender_pkg;

    localparam int DEF_WIDTH     = 40;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_GAP       = 8;
    localparam int DEF_LSB_FIRST = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/frame_sender_if.sv
// Payload handshake and serial-line status bundle between a producer and frame_sender.
interface frame_sender_if
    import sender_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    logic [WIDTH-1:0]         in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     sout;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     frame_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, sout, busy, fifo_count, frame_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sout, busy, fifo_count, frame_done
    );

endinterface

// File: rtl/frame_fifo.sv
// Power-of-two frame queue with registered pointers and occupancy count, falling-edge clocked.
module frame_fifo
    import sender_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, gated by count.
    always_ff @(negedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/frame_sender.sv
// Queues payload words and serialises each as a start bit plus payload, followed by an idle gap.
module frame_sender
    import sender_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int GAP       = DEF_GAP,
    parameter int LSB_FIRST = DEF_LSB_FIRST
) (
    input logic           clk,
    input logic           rst,
    frame_sender_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0] BIT_END  = BW'(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP);

    state_e           state_q, state_d;
    logic [WIDTH:0]   frame_q, frame_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             sout_q, sout_d;
    logic             frame_done_q, frame_done_d;
    logic             push, pop, full, empty;
    logic [WIDTH-1:0] head, payload;
    logic [IW-1:0]    bit_idx;
    logic [CW-1:0]    count;

    // in_ready comes from the pre-edge count, so a pop never frees a slot for the same edge.
    assign push = bus.in_valid && !full;
    assign pop  = (state_q == ST_IDLE) && !empty;

    frame_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.in_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign payload = frame_q[WIDTH-1:0];
    assign bit_idx = (LSB_FIRST != 0) ? IW'(bit_cnt_q) : IW'(BIT_LAST - bit_cnt_q);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sout_d       = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    frame_d   = {1'b1, head};
                    bit_cnt_d = '0;
                    sout_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_END) begin
                    frame_done_d = 1'b1;
                    gap_cnt_d    = GW'(1);
                    state_d      = ST_GAP;
                end else begin
                    sout_d    = payload[bit_idx];
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_END) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            sout_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sout_q       <= sout_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.sout       = sout_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != ST_IDLE) || !empty;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_frame_sender.sv
// Random and directed stimulus for three frame_sender configurations against a frame-timeline model.
module tb_frame_sender;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Channel 0: 40-bit MSB first; channel 1: 40-bit LSB first; channel 2: 1-bit, GAP=1, DEPTH=2.
    frame_sender_if #(.WIDTH(40), .DEPTH(4)) bus0 ();
    frame_sender_if #(.WIDTH(40), .DEPTH(4)) bus1 ();
    frame_sender_if #(.WIDTH(1),  .DEPTH(2)) bus2 ();

    frame_sender #(.WIDTH(40), .DEPTH(4), .GAP(8), .LSB_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    frame_sender #(.WIDTH(40), .DEPTH(4), .GAP(8), .LSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    frame_sender #(.WIDTH(1),  .DEPTH(2), .GAP(1), .LSB_FIRST(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0][39:0] drv_data;
    logic [2:0]       drv_valid;
    logic [2:0]       m_sout, m_done, m_busy, m_ready;
    logic [2:0][7:0]  m_cnt;

    assign bus0.in_data  = drv_data[0];
    assign bus1.in_data  = drv_data[1];
    assign bus2.in_data  = drv_data[2][0:0];
    assign bus0.in_valid = drv_valid[0];
    assign bus1.in_valid = drv_valid[1];
    assign bus2.in_valid = drv_valid[2];

    assign m_sout  = {bus2.sout, bus1.sout, bus0.sout};
    assign m_done  = {bus2.frame_done, bus1.frame_done, bus0.frame_done};
    assign m_busy  = {bus2.busy, bus1.busy, bus0.busy};
    assign m_ready = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign m_cnt[0] = 8'(bus0.fifo_count);
    assign m_cnt[1] = 8'(bus1.fifo_count);
    assign m_cnt[2] = 8'(bus2.fifo_count);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int ch);
        return (ch == 2) ? 1 : 40;
    endfunction
    function automatic int g_of(input int ch);
        return (ch == 2) ? 1 : 8;
    endfunction
    function automatic int d_of(input int ch);
        return (ch == 2) ? 2 : 4;
    endfunction
    function automatic int lsb_of(input int ch);
        return (ch == 1) ? 1 : 0;
    endfunction

    // Model: every accepted word gets a start edge = max(push+1, previous start + W + G + 2).
    // Start bit follows that edge, payload bits the next W edges, frame_done the edge after.
    typedef struct {
        logic [39:0] data;
        int          start;
    } frame_t;

    frame_t fr [3][16];
    int     nfr [3]        = '{0, 0, 0};
    int     last_start [3] = '{-1000, -1000, -1000};
    int     acc_start [3]  = '{0, 0, 0};
    bit     accepted [3]   = '{0, 0, 0};
    int     cyc = 0;

    always @(negedge clk) begin
        cyc++;
        for (int ch = 0; ch < 3; ch++) begin
            int k, pend, s;
            logic [39:0] m;
            accepted[ch] = 1'b0;
            if (rst) begin
                nfr[ch]        = 0;
                last_start[ch] = -1000;
            end else begin
                k = 0;
                for (int i = 0; i < nfr[ch]; i++) begin
                    if (fr[ch][i].start + w_of(ch) + g_of(ch) >= cyc) begin
                        fr[ch][k] = fr[ch][i];
                        k++;
                    end
                end
                nfr[ch] = k;
                pend = 0;
                for (int i = 0; i < nfr[ch]; i++) if (fr[ch][i].start >= cyc) pend++;
                if (drv_valid[ch] && pend < d_of(ch) && nfr[ch] < 16) begin
                    s = cyc + 1;
                    if (last_start[ch] + w_of(ch) + g_of(ch) + 2 > s) s = last_start[ch] + w_of(ch) + g_of(ch) + 2;
                    m = '1;
                    m = m >> (40 - w_of(ch));
                    fr[ch][nfr[ch]].data  = drv_data[ch] & m;
                    fr[ch][nfr[ch]].start = s;
                    nfr[ch]++;
                    last_start[ch] = s;
                    acc_start[ch]  = s;
                    accepted[ch]   = 1'b1;
                end
            end
        end
    end

    // Compare every channel's outputs mid-cycle against the model timeline.
    always @(posedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            logic s_e, d_e, b_e;
            logic [39:0] sh;
            int c_e, j, st;
            s_e = 1'b0; d_e = 1'b0; b_e = 1'b0; c_e = 0;
            for (int i = 0; i < nfr[ch]; i++) begin
                st = fr[ch][i].start;
                if (st > cyc) begin
                    c_e++;
                end else begin
                    if (cyc == st) begin
                        s_e = 1'b1;
                    end else if (cyc <= st + w_of(ch)) begin
                        j  = cyc - st - 1;
                        sh = fr[ch][i].data >> ((lsb_of(ch) != 0) ? j : (w_of(ch) - 1 - j));
                        s_e = sh[0];
                    end
                    if (cyc == st + w_of(ch) + 1) d_e = 1'b1;
                    if (cyc <= st + w_of(ch) + g_of(ch)) b_e = 1'b1;
                end
            end
            if (c_e > 0) b_e = 1'b1;
            check($sformatf("ch%0d sout @%0d", ch, cyc), 64'(m_sout[ch]), 64'(s_e));
            check($sformatf("ch%0d frame_done @%0d", ch, cyc), 64'(m_done[ch]), 64'(d_e));
            check($sformatf("ch%0d busy @%0d", ch, cyc), 64'(m_busy[ch]), 64'(b_e));
            check($sformatf("ch%0d fifo_count @%0d", ch, cyc), 64'(m_cnt[ch]), 64'(c_e));
            check($sformatf("ch%0d in_ready @%0d", ch, cyc), 64'(m_ready[ch]), 64'(c_e < d_of(ch)));
        end
    end

    task automatic send(input int ch, input logic [39:0] d);
        drv_data[ch]  = d;
        drv_valid[ch] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (accepted[ch]) break;
        end
        drv_valid[ch] = 1'b0;
    endtask

    initial begin
        int          s0;
        logic [63:0] r;
        drv_valid = '0;
        drv_data  = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single frame followed by a six-word burst that overfills the queue.
        send(0, 40'hD999999991);
        for (int i = 0; i < 4; i++) send(0, 40'h1000000001 * (i + 3));
        check("burst count after 4th push", 64'(m_cnt[0]), 64'd4);
        check("burst in_ready after 4th push", 64'(m_ready[0]), 64'd0);
        send(0, 40'hF0F0F0F0F0);
        send(0, 40'h0F0F0F0F0F);

        send(1, 40'hD999999991);
        send(2, 40'h1);
        send(2, 40'h0);
        send(2, 40'h1);
        send(2, 40'h1);
        repeat (400) @(posedge clk);

        // Reset while payload bit 17 is on the line with two words still queued.
        send(0, 40'hA5C3_96E1_7B);
        s0 = acc_start[0];
        send(0, 40'h1122334455);
        send(0, 40'h6677889900);
        while (cyc < s0 + 18) @(posedge clk);
        check("pre-reset fifo_count", 64'(m_cnt[0]), 64'd2);
        #1 rst = 1'b1;
        #1;
        check("reset sout", 64'(m_sout[0]), 64'd0);
        check("reset frame_done", 64'(m_done[0]), 64'd0);
        check("reset busy", 64'(m_busy[0]), 64'd0);
        check("reset fifo_count", 64'(m_cnt[0]), 64'd0);
        check("reset in_ready", 64'(m_ready[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(0, 40'h8000000001);
        repeat (70) @(posedge clk);

        // Randomised traffic on all channels; a word is held until the model accepts it.
        repeat (600) begin
            @(negedge clk);
            #1;
            for (int ch = 0; ch < 3; ch++) begin
                if (!drv_valid[ch] || accepted[ch]) begin
                    r = {$urandom(), $urandom()};
                    drv_data[ch]  = r[39:0];
                    drv_valid[ch] = ($urandom_range(0, 99) < 70);
                end
            end
        end
        @(negedge clk);
        #1;
        drv_valid = '0;
        repeat (400) @(posedge clk);
        #1;
        check("drained busy ch0", 64'(m_busy[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
